// File: rtl/screen_pkg.sv
// Shared constants for the screen sequencer: screen codes, end causes, colour width.
package screen_pkg;
  localparam int RGB_W = 12;

  localparam logic [1:0] SCR_TITLE = 2'd0;
  localparam logic [1:0] SCR_PLAY  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;

  localparam logic [1:0] END_NONE  = 2'b00;
  localparam logic [1:0] END_LIVES = 2'b01;
  localparam logic [1:0] END_TIME  = 2'b10;

  // State encoding doubles as the screen code; ST_BAD exists only so recovery is explicit.
  typedef enum logic [1:0] {
    ST_TITLE = SCR_TITLE,
    ST_PLAY  = SCR_PLAY,
    ST_OVER  = SCR_OVER,
    ST_BAD   = 2'd3
  } state_t;
endpackage

// File: rtl/edge_det.sv
// One-bit registered edge detector; RISE selects rising (1) or falling (0) edge output.
module edge_det #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   RISE    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic q;

  // Previous-cycle sample; reset value chosen so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) q <= RST_VAL;
    else       q <= d;
  end

  assign pulse = RISE ? (d & ~q) : (q & ~d);
endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: TITLE -> PLAY -> OVER on frame boundaries, hold timers, colour mux.
// Optional feature: define SEQ_TIMEOUT_EN to enable the GAME_FRAMES play timer.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int GAME_FRAMES = 1800,
  parameter int HOLD_FRAMES = 180,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             start_btn,
  input  logic             lives_zero,
  input  logic [RGB_W-1:0] title_rgb,
  input  logic [RGB_W-1:0] play_rgb,
  input  logic [RGB_W-1:0] over_rgb,
  output logic [RGB_W-1:0] rgb_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [1:0]       screen,
  output logic             game_en,
  output logic             game_rst,
  output logic [1:0]       end_cause,
  output logic [CNT_W-1:0] time_left
);
  logic       frame_tick, start_rise;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic [1:0] cause_q, cause_d;
  logic       rst_q, rst_d;
`ifdef SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] time_q, time_d;
`endif

  edge_det #(.RST_VAL(1'b1), .RISE(1'b0)) u_vs_fall (
    .clk(clk), .reset(reset), .d(vsync_in), .pulse(frame_tick));
  edge_det #(.RST_VAL(1'b0), .RISE(1'b1)) u_start_rise (
    .clk(clk), .reset(reset), .d(start_btn), .pulse(start_rise));

  // Next-state and counter updates; everything moves only on frame_tick except start capture.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    cause_d = cause_q;
    rst_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    time_d  = time_q;
`endif
    case (state_q)
      ST_TITLE: begin
        if (start_rise) pend_d = 1'b1;
        // A start edge landing on the tick itself still launches on that tick.
        if (frame_tick && (pend_q || start_rise)) begin
          state_d = ST_PLAY;
          pend_d  = 1'b0;
          rst_d   = 1'b1;
          cause_d = END_NONE;
`ifdef SEQ_TIMEOUT_EN
          time_d  = CNT_W'(GAME_FRAMES);
`endif
        end
      end
      ST_PLAY: begin
        pend_d = 1'b0;
        if (frame_tick) begin
          if (lives_zero) begin
            state_d = ST_OVER;
            cause_d = END_LIVES;
            hold_d  = CNT_W'(HOLD_FRAMES);
          end
`ifdef SEQ_TIMEOUT_EN
          else begin
            if (time_q != '0) time_d = time_q - CNT_W'(1);
            if (time_q <= CNT_W'(1)) begin
              state_d = ST_OVER;
              cause_d = END_TIME;
              hold_d  = CNT_W'(HOLD_FRAMES);
            end
          end
`endif
        end
      end
      ST_OVER: begin
        pend_d = 1'b0;
        if (frame_tick) begin
          if (hold_q != '0) hold_d = hold_q - CNT_W'(1);
          if (hold_q <= CNT_W'(1)) state_d = ST_TITLE;
        end
      end
      default: begin
        state_d = ST_TITLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_TITLE;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      cause_q <= END_NONE;
      rst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      rst_q   <= rst_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // Play timer register.
  always_ff @(posedge clk) begin
    if (reset) time_q <= '0;
    else       time_q <= time_d;
  end
  assign time_left = time_q;
`else
  assign time_left = '0;
`endif

  // Output stage: colour source and syncs share the same single register delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      case (state_q)
        ST_TITLE: rgb_out <= title_rgb;
        ST_PLAY:  rgb_out <= play_rgb;
        ST_OVER:  rgb_out <= over_rgb;
        default:  rgb_out <= '0;
      endcase
    end
  end

  assign screen    = state_q;
  assign game_en   = (state_q == ST_PLAY);
  assign game_rst  = rst_q;
  assign end_cause = cause_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with GAME_FRAMES=4, HOLD_FRAMES=2, 20-clock frames.
module tb_screen_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = 1'b1, vsync_in = 1'b1;
  logic        start_btn = 1'b0, lives_zero = 1'b0;
  logic [11:0] title_rgb = 12'hABC, play_rgb = 12'h0F0, over_rgb = 12'hF00;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out;
  logic [1:0]  screen;
  logic        game_en, game_rst;
  logic [1:0]  end_cause;
  logic [11:0] time_left;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  logic tick_now = 1'b0;

  screen_sequencer #(.GAME_FRAMES(4), .HOLD_FRAMES(2), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .start_btn(start_btn), .lives_zero(lives_zero),
    .title_rgb(title_rgb), .play_rgb(play_rgb), .over_rgb(over_rgb),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .screen(screen), .game_en(game_en), .game_rst(game_rst),
    .end_cause(end_cause), .time_left(time_left));

  always #5 clk = ~clk;

  // Synthetic sync stream: vsync low for 2 of every 20 clocks, hsync low every 10.
  initial begin
    forever begin
      @(negedge clk);
      vsync_in = !(ph < 2);
      hsync_in = (ph % 10 != 5);
      tick_now = (ph == 0);
      ph = (ph + 1) % 20;
    end
  end

  // Stop at the negedge where vsync has just fallen (the tick cycle).
  task automatic find_tick_negedge();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!tick_now && n < 30);
    if (!tick_now) begin
      checks++; errors++;
      $display("FAIL tick_timeout: no vsync fall within %0d clocks", n);
    end
  endtask

  // Advance to just after the edge that ends the next tick cycle.
  task automatic wait_tick();
    find_tick_negedge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rgb_out !== 12'h000) begin errors++; $display("FAIL rst_rgb: got %h exp 000", rgb_out); end
    checks++; if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin errors++; $display("FAIL rst_sync: got %b%b exp 11", hsync_out, vsync_out); end
    checks++; if (screen !== 2'd0 || game_en !== 1'b0 || game_rst !== 1'b0) begin errors++; $display("FAIL rst_state: scr %0d en %b rst %b exp 0 0 0", screen, game_en, game_rst); end
    checks++; if (end_cause !== 2'b00 || time_left !== 12'd0) begin errors++; $display("FAIL rst_cnt: cause %b tl %0d exp 00 0", end_cause, time_left); end
    @(negedge clk);
    reset = 1'b0;
    title_rgb = 12'h00F;
    @(posedge clk); #1;
    checks++; if (rgb_out !== 12'h00F) begin errors++; $display("FAIL title_rgb: got %h exp 00F", rgb_out); end
    // Sync outputs track inputs with one clock of delay across a whole frame.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (vsync_out !== vsync_in || hsync_out !== hsync_in || rgb_out !== 12'h00F) begin
        errors++;
        $display("FAIL sync_align: vs %b hs %b rgb %h exp %b %b 00F", vsync_out, hsync_out, rgb_out, vsync_in, hsync_in);
      end
    end
  endtask

  task automatic test_start_timeout();
    find_tick_negedge();
    repeat (5) @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(posedge clk); #1;
    checks++; if (screen !== 2'd0) begin errors++; $display("FAIL start_early: screen %0d exp 0", screen); end
    wait_tick();
    checks++; if (screen !== 2'd1 || game_en !== 1'b1) begin errors++; $display("FAIL start_play: screen %0d en %b exp 1 1", screen, game_en); end
    checks++; if (game_rst !== 1'b1) begin errors++; $display("FAIL start_rst: got %b exp 1", game_rst); end
    checks++; if (rgb_out !== 12'h00F) begin errors++; $display("FAIL start_rgb_lag: got %h exp 00F", rgb_out); end
`ifdef SEQ_TIMEOUT_EN
    checks++; if (time_left !== 12'd4) begin errors++; $display("FAIL start_tl: got %0d exp 4", time_left); end
`else
    checks++; if (time_left !== 12'd0) begin errors++; $display("FAIL start_tl: got %0d exp 0", time_left); end
`endif
    @(posedge clk); #1;
    checks++; if (game_rst !== 1'b0) begin errors++; $display("FAIL rst_width: got %b exp 0", game_rst); end
    checks++; if (rgb_out !== 12'h0F0) begin errors++; $display("FAIL play_rgb: got %h exp 0F0", rgb_out); end
`ifdef SEQ_TIMEOUT_EN
    for (int k = 3; k >= 1; k--) begin
      wait_tick();
      checks++; if (time_left !== 12'(k) || screen !== 2'd1) begin errors++; $display("FAIL tl_count: tl %0d scr %0d exp %0d 1", time_left, screen, k); end
    end
    wait_tick();
    checks++; if (screen !== 2'd2 || end_cause !== 2'b10) begin errors++; $display("FAIL timeout: scr %0d cause %b exp 2 10", screen, end_cause); end
`else
    for (int k = 0; k < 10; k++) begin
      wait_tick();
      checks++; if (screen !== 2'd1 || time_left !== 12'd0) begin errors++; $display("FAIL no_timeout: scr %0d tl %0d exp 1 0", screen, time_left); end
    end
    @(negedge clk);
    lives_zero = 1'b1;
    wait_tick();
    lives_zero = 1'b0;
    checks++; if (screen !== 2'd2 || end_cause !== 2'b01) begin errors++; $display("FAIL lives_end: scr %0d cause %b exp 2 01", screen, end_cause); end
`endif
    @(posedge clk); #1;
    checks++; if (rgb_out !== 12'hF00 || game_en !== 1'b0) begin errors++; $display("FAIL over_rgb: rgb %h en %b exp F00 0", rgb_out, game_en); end
    wait_tick();
    checks++; if (screen !== 2'd2) begin errors++; $display("FAIL hold1: scr %0d exp 2", screen); end
    wait_tick();
    checks++; if (screen !== 2'd0) begin errors++; $display("FAIL hold2: scr %0d exp 0", screen); end
  endtask

  task automatic test_lives_and_time();
    // Start on the tick itself (start edge and vsync fall in the same cycle).
    find_tick_negedge();
    start_btn = 1'b1;
    @(posedge clk); #1;
    checks++; if (screen !== 2'd1 || game_rst !== 1'b1 || end_cause !== 2'b00) begin errors++; $display("FAIL same_cycle_start: scr %0d rst %b cause %b exp 1 1 00", screen, game_rst, end_cause); end
    @(negedge clk);
    start_btn = 1'b0;
    repeat (3) wait_tick();
`ifdef SEQ_TIMEOUT_EN
    checks++; if (time_left !== 12'd1) begin errors++; $display("FAIL lt_tl: got %0d exp 1", time_left); end
`endif
    @(negedge clk);
    lives_zero = 1'b1;
    wait_tick();
    checks++; if (screen !== 2'd2 || end_cause !== 2'b01) begin errors++; $display("FAIL lives_wins: scr %0d cause %b exp 2 01", screen, end_cause); end
    @(negedge clk);
    lives_zero = 1'b0;
  endtask

  task automatic test_ignored_start();
    // Start rises in OVER and stays high into TITLE.
    @(negedge clk);
    start_btn = 1'b1;
    wait_tick();
    checks++; if (screen !== 2'd2) begin errors++; $display("FAIL ign_over: scr %0d exp 2", screen); end
    wait_tick();
    checks++; if (screen !== 2'd0) begin errors++; $display("FAIL ign_title: scr %0d exp 0", screen); end
    for (int k = 0; k < 2; k++) begin
      wait_tick();
      checks++; if (screen !== 2'd0 || game_rst !== 1'b0) begin errors++; $display("FAIL ign_held: scr %0d rst %b exp 0 0", screen, game_rst); end
    end
    @(negedge clk);
    start_btn = 1'b0;
    repeat (3) @(negedge clk);
    start_btn = 1'b1;
    wait_tick();
    checks++; if (screen !== 2'd1 || game_rst !== 1'b1) begin errors++; $display("FAIL fresh_start: scr %0d rst %b exp 1 1", screen, game_rst); end
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (2) wait_tick();
`ifdef SEQ_TIMEOUT_EN
    checks++; if (time_left !== 12'd2) begin errors++; $display("FAIL mid_tl: got %0d exp 2", time_left); end
`endif
    checks++; if (screen !== 2'd1) begin errors++; $display("FAIL mid_play: scr %0d exp 1", screen); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (screen !== 2'd0 || game_en !== 1'b0 || time_left !== 12'd0) begin errors++; $display("FAIL mid_reset: scr %0d en %b tl %0d exp 0 0 0", screen, game_en, time_left); end
    checks++; if (end_cause !== 2'b00 || rgb_out !== 12'h000) begin errors++; $display("FAIL mid_reset_out: cause %b rgb %h exp 00 000", end_cause, rgb_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_timeout();
    test_lives_and_time();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
